logic_unit_pipe: RTL

- Parametrised successor to the fixed 4-bit bitwise AND array: a WIDTH-bit bitwise logic unit with eight selectable operations.
- Two-stage registered pipeline with valid/ready handshakes on input and output.
- Result-status flags and a wrapping count of completed transactions.
- Sits between a register-file/operand source and any downstream consumer that may apply backpressure.

---
 rtl/logic_unit_pipe_if.sv | 29 ++
 rtl/logic_unit_pipe.sv | 96 +++++++++
 2 files changed

// File: rtl/logic_unit_pipe_if.sv
// Operand/result handshake bundle for logic_unit_pipe.
// The slave modport is the unit's view; the master modport is the source/consumer side.
interface logic_unit_pipe_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_op;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic             out_ones;
  logic             out_parity;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] txn_count;

  modport master (
    output in_a, in_b, in_op, in_valid, out_ready,
    input  in_ready, out_result, out_zero, out_ones, out_parity, out_valid, txn_count
  );

  modport slave (
    input  in_a, in_b, in_op, in_valid, out_ready,
    output in_ready, out_result, out_zero, out_ones, out_parity, out_valid, txn_count
  );
endinterface

// File: rtl/logic_unit_pipe.sv
// WIDTH-bit bitwise logic unit with eight operations, a two-stage valid/ready
// pipeline, registered result flags and a wrapping output-handshake counter.
module logic_unit_pipe #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input logic            clk,
  input logic            rst_n,
  logic_unit_pipe_if.slave bus
);

  function automatic logic [WIDTH-1:0] op_fn(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [2:0]       op
  );
    case (op)
      3'b000:  op_fn = a & b;
      3'b001:  op_fn = a | b;
      3'b010:  op_fn = a ^ b;
      3'b011:  op_fn = ~(a & b);
      3'b100:  op_fn = ~(a | b);
      3'b101:  op_fn = ~(a ^ b);
      3'b110:  op_fn = a & ~b;
      default: op_fn = a;
    endcase
  endfunction

  function automatic logic [2:0] flags_fn(input logic [WIDTH-1:0] res);
    flags_fn = {~|res, &res, ^res};
  endfunction

  logic             w_s1_load;
  logic             w_s2_load;
  logic [2:0]       w_flags_p1;
  logic             r_vld_p1;
  logic [WIDTH-1:0] r_res_p1;
  logic             r_vld_p2;
  logic [WIDTH-1:0] r_res_p2;
  logic             r_zero_p2;
  logic             r_ones_p2;
  logic             r_par_p2;
  logic [CNT_W-1:0] r_cnt;

  // A stage may load when it is empty or its contents move on this edge.
  assign w_s2_load  = !r_vld_p2 || bus.out_ready;
  assign w_s1_load  = !r_vld_p1 || w_s2_load;
  assign w_flags_p1 = flags_fn(r_res_p1);

  // Stage 1: operation result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1 <= 1'b0;
      r_res_p1 <= '0;
    end else if (w_s1_load) begin
      r_vld_p1 <= bus.in_valid;
      if (bus.in_valid) r_res_p1 <= op_fn(bus.in_a, bus.in_b, bus.in_op);
    end
  end

  // Stage 2: result plus status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p2  <= 1'b0;
      r_res_p2  <= '0;
      r_zero_p2 <= 1'b0;
      r_ones_p2 <= 1'b0;
      r_par_p2  <= 1'b0;
    end else if (w_s2_load) begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_res_p2  <= r_res_p1;
        r_zero_p2 <= w_flags_p1[2];
        r_ones_p2 <= w_flags_p1[1];
        r_par_p2  <= w_flags_p1[0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_vld_p2 && bus.out_ready) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign bus.in_ready   = w_s1_load;
  assign bus.out_valid  = r_vld_p2;
  assign bus.out_result = r_res_p2;
  assign bus.out_zero   = r_zero_p2;
  assign bus.out_ones   = r_ones_p2;
  assign bus.out_parity = r_par_p2;
  assign bus.txn_count  = r_cnt;

endmodule
